pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of forwarded operands.
REQ-002 Parameter DEPTH, default 3, number of tracked post-ID stages; index 0 = EX, 1 = MEM, 2 = WB; legal range 2..6.
REQ-003 Parameter LD_READY, default 1, lowest stage index at which load data is forwardable; legal range 1..DEPTH-1.
REQ-004 Parameter SELW, default 2, width of forward selects, equal to clog2(DEPTH+1).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_rs1, id_rs2  in  5 each  source register indices.
REQ-009 id_re1, id_re2  in  1 each  source actually read.
REQ-010 id_rd  in  5  destination register index.
REQ-011 id_rfwe  in  1  instruction writes the register file.
REQ-012 id_is_load  in  1  instruction is a load.
REQ-013 flush  in  1  branch/jump taken in ID; discard the ID instruction.
REQ-014 mem_stall  in  1  data memory not ready; freeze the whole pipeline.
REQ-015 stage_wd  in  DEPTH*XLEN  per-stage write-back value, slice k = stage k.
REQ-016 stall_if_id  out  1  hold PC and IF/ID register.
REQ-017 bubble_ex  out  1  load NOP into ID/EX.
REQ-018 fwd1_sel, fwd2_sel  out  SELW each  0 = register file, k+1 = stage k.
REQ-019 fwd1_data, fwd2_data  out  XLEN each  selected stage_wd slice; 0 when sel = 0.
REQ-020 luse_cnt  out  32  saturating count of load-use stall cycles.

Function
REQ-021 Shadow pipeline of DEPTH entries, each {v, rd, we, ld}, mirrors the destination info of in-flight instructions.
REQ-022 Advance when mem_stall=0: entry k <= entry k-1 for k>=1; entry 0 <= ID info if id_valid & !flush & !luse, else bubble (v=0).
REQ-023 When mem_stall=1: all entries and luse_cnt hold.
REQ-024 Match for source s at stage k: re_s & v[k] & we[k] & rd[k]==rs_s & rs_s!=0.
REQ-025 Priority: lowest matching k wins; no match gives sel = 0.
REQ-026 luse = id_valid & !flush & (winning match at k < LD_READY with ld[k]=1), for either source.
REQ-027 When luse=1, fwd sel/data are don't-care; the bench does not check them.
REQ-028 stall_if_id = mem_stall | luse.
REQ-029 bubble_ex = luse & !mem_stall.
REQ-030 flush=1 suppresses luse in the same cycle; flush wins.
REQ-031 luse_cnt increments by 1 per cycle with luse & !mem_stall and saturates at 0xFFFFFFFF.
REQ-032 Hazard outputs are combinational from shadow state and ID inputs, with zero-cycle latency; shadow update has one-cycle latency.
REQ-033 x0 is never forwarded and never causes a stall.
REQ-034 Generate-based logic; no DEPTH-specific hardcoding.

Reset
REQ-035 rst_n=0 at a clock edge clears all v, rd, we and ld fields and luse_cnt to 0.
REQ-036 While rst_n=0, shadow state is zero, so stall_if_id=mem_stall, bubble_ex=0, fwd sels=0 and fwd data=0.
REQ-037 Reset asserted mid-stall drops the stall on the next edge; no pending hazard survives.

Verification
REQ-038 ALU dependency: add x5 enters EX, then ID reads rs1=5 with stage_wd[0]=0x11 -> fwd1_sel=1, fwd1_data=0x11, no stall.
REQ-039 Priority: x7 written in EX (0xA) and MEM (0xB), ID reads rs2=7 -> fwd2_sel=1, fwd2_data=0xA.
REQ-040 Load-use: lw x3 in EX, ID reads x3 -> stall_if_id=1, bubble_ex=1, luse_cnt 0->1; next cycle, lw in MEM -> fwd1_sel=2, no stall.
REQ-041 Flush and mem_stall: luse condition with flush=1 -> no stall, entry 0 becomes a bubble; mem_stall=1 for 3 cycles -> stall_if_id=1, bubble_ex=0, shadow and luse_cnt unchanged.
REQ-042 x0 and reset: ID reads x0 while EX writes x0 -> sel 0; rst_n=0 during a load-use stall -> next cycle all outputs 0, luse_cnt=0.
REQ-043 Parameter sweep: DEPTH=4, LD_READY=2 -> load stalls for 2 cycles before forwarding from stage 2 (sel=3).

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Data-hazard unit for an in-order pipeline: tracks destinations of in-flight
// instructions, selects operand forwarding and raises load-use stalls.
module pipe_hazard_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LD_READY = 1,
  parameter int unsigned SELW     = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [4:0]            i_id_rs1,
  input  logic [4:0]            i_id_rs2,
  input  logic                  i_id_re1,
  input  logic                  i_id_re2,
  input  logic [4:0]            i_id_rd,
  input  logic                  i_id_rfwe,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  input  logic                  i_mem_stall,
  input  logic [DEPTH*XLEN-1:0] i_stage_wd,
  output logic                  o_stall_if_id,
  output logic                  o_bubble_ex,
  output logic [SELW-1:0]       o_fwd1_sel,
  output logic [SELW-1:0]       o_fwd2_sel,
  output logic [XLEN-1:0]       o_fwd1_data,
  output logic [XLEN-1:0]       o_fwd2_data,
  output logic [31:0]           o_luse_cnt
);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_we;
  logic [DEPTH-1:0] r_ld;
  logic [4:0]       r_rd [DEPTH];
  logic [31:0]      r_luse_cnt;

  logic [DEPTH-1:0] w_m1;
  logic [DEPTH-1:0] w_m2;
  logic [SELW-1:0]  w_sel1;
  logic [SELW-1:0]  w_sel2;
  logic             w_haz1;
  logic             w_haz2;
  logic [XLEN-1:0]  w_d1;
  logic [XLEN-1:0]  w_d2;
  logic             w_luse;
  logic             w_issue;

  // Matches are gated by reset so the outputs look like an empty pipe while
  // reset is held, even before the first clearing edge.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign w_m1[g] = i_rst_n & i_id_re1 & r_v[g] & r_we[g] &
                     (r_rd[g] == i_id_rs1) & (i_id_rs1 != 5'd0);
    assign w_m2[g] = i_rst_n & i_id_re2 & r_v[g] & r_we[g] &
                     (r_rd[g] == i_id_rs2) & (i_id_rs2 != 5'd0);
  end

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_m1[k]) begin
        w_sel1 = SELW'(k + 1);
        w_haz1 = (k < int'(LD_READY)) && r_ld[k];
      end
      if (w_m2[k]) begin
        w_sel2 = SELW'(k + 1);
        w_haz2 = (k < int'(LD_READY)) && r_ld[k];
      end
    end
  end

  always_comb begin
    w_d1 = '0;
    w_d2 = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (w_sel1 == SELW'(k + 1)) w_d1 = i_stage_wd[k*XLEN +: XLEN];
      if (w_sel2 == SELW'(k + 1)) w_d2 = i_stage_wd[k*XLEN +: XLEN];
    end
  end

  assign w_luse  = i_id_valid & ~i_flush & (w_haz1 | w_haz2);
  assign w_issue = i_id_valid & ~i_flush & ~w_luse;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v        <= '0;
      r_we       <= '0;
      r_ld       <= '0;
      r_luse_cnt <= '0;
      for (int k = 0; k < int'(DEPTH); k++) r_rd[k] <= '0;
    end else if (!i_mem_stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_v[k]  <= r_v[k-1];
        r_we[k] <= r_we[k-1];
        r_ld[k] <= r_ld[k-1];
        r_rd[k] <= r_rd[k-1];
      end
      if (w_issue) begin
        r_v[0]  <= 1'b1;
        r_we[0] <= i_id_rfwe;
        r_ld[0] <= i_id_is_load;
        r_rd[0] <= i_id_rd;
      end else begin
        r_v[0]  <= 1'b0;
        r_we[0] <= 1'b0;
        r_ld[0] <= 1'b0;
        r_rd[0] <= '0;
      end
      if (w_luse && (r_luse_cnt != 32'hFFFF_FFFF)) r_luse_cnt <= r_luse_cnt + 32'd1;
    end
  end

  assign o_stall_if_id = i_mem_stall | w_luse;
  assign o_bubble_ex   = w_luse & ~i_mem_stall;
  assign o_fwd1_sel    = w_sel1;
  assign o_fwd2_sel    = w_sel2;
  assign o_fwd1_data   = w_d1;
  assign o_fwd2_data   = w_d2;
  assign o_luse_cnt    = r_luse_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: two configurations (3 stages/ready 1, 4 stages/ready 2)
// share one stimulus stream and are checked against an in-flight-list model.
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        luse;
    logic [31:0] sel1;
    logic [31:0] sel2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic         rst_n;
    logic         valid;
    logic         re1;
    logic         re2;
    logic         rfwe;
    logic         ld;
    logic         flush;
    logic         stall;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [127:0] wd;
  } stim_t;

  logic         clk = 1'b0;
  logic         s_rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_re1 = 1'b0;
  logic         s_re2 = 1'b0;
  logic         s_rfwe = 1'b0;
  logic         s_ld = 1'b0;
  logic         s_flush = 1'b0;
  logic         s_stall = 1'b0;
  logic [4:0]   s_rs1 = '0;
  logic [4:0]   s_rs2 = '0;
  logic [4:0]   s_rd = '0;
  logic [127:0] s_wd = '0;

  logic        o0_stall, o0_bubble;
  logic [1:0]  o0_sel1, o0_sel2;
  logic [31:0] o0_d1, o0_d2, o0_cnt;
  logic        o1_stall, o1_bubble;
  logic [2:0]  o1_sel1, o1_sel2;
  logic [31:0] o1_d1, o1_d2, o1_cnt;

  int n_checks = 0;
  int n_err    = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Model state: in-flight list, youngest first, plus stall counters.
  ent_t        sh [2][4];
  logic [31:0] cnt_m [2];

  always #5 clk = ~clk;

  pipe_hazard_unit #(.XLEN(32), .DEPTH(3), .LD_READY(1), .SELW(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(s_rst_n), .i_id_valid(s_valid),
    .i_id_rs1(s_rs1), .i_id_rs2(s_rs2), .i_id_re1(s_re1), .i_id_re2(s_re2),
    .i_id_rd(s_rd), .i_id_rfwe(s_rfwe), .i_id_is_load(s_ld),
    .i_flush(s_flush), .i_mem_stall(s_stall), .i_stage_wd(s_wd[95:0]),
    .o_stall_if_id(o0_stall), .o_bubble_ex(o0_bubble),
    .o_fwd1_sel(o0_sel1), .o_fwd2_sel(o0_sel2),
    .o_fwd1_data(o0_d1), .o_fwd2_data(o0_d2), .o_luse_cnt(o0_cnt)
  );

  pipe_hazard_unit #(.XLEN(32), .DEPTH(4), .LD_READY(2), .SELW(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(s_rst_n), .i_id_valid(s_valid),
    .i_id_rs1(s_rs1), .i_id_rs2(s_rs2), .i_id_re1(s_re1), .i_id_re2(s_re2),
    .i_id_rd(s_rd), .i_id_rfwe(s_rfwe), .i_id_is_load(s_ld),
    .i_flush(s_flush), .i_mem_stall(s_stall), .i_stage_wd(s_wd),
    .o_stall_if_id(o1_stall), .o_bubble_ex(o1_bubble),
    .o_fwd1_sel(o1_sel1), .o_fwd2_sel(o1_sel2),
    .o_fwd1_data(o1_d1), .o_fwd2_data(o1_d2), .o_luse_cnt(o1_cnt)
  );

  // Youngest in-flight writer of rs wins; its age decides if a load is still pending.
  function automatic exp_t predict(input int c);
    exp_t e;
    int   depth;
    int   ldr;
    logic h1;
    logic h2;
    depth = (c == 0) ? 3 : 4;
    ldr   = (c == 0) ? 1 : 2;
    e = '0;
    h1 = 1'b0;
    h2 = 1'b0;
    for (int k = 0; k < depth; k++) begin
      if (e.sel1 == 0 && s_rst_n && s_re1 && s_rs1 != 0 && sh[c][k].v &&
          sh[c][k].we && sh[c][k].rd == s_rs1) begin
        e.sel1 = 32'(k + 1);
        e.d1   = s_wd[k*32 +: 32];
        h1     = sh[c][k].ld && (k < ldr);
      end
      if (e.sel2 == 0 && s_rst_n && s_re2 && s_rs2 != 0 && sh[c][k].v &&
          sh[c][k].we && sh[c][k].rd == s_rs2) begin
        e.sel2 = 32'(k + 1);
        e.d2   = s_wd[k*32 +: 32];
        h2     = sh[c][k].ld && (k < ldr);
      end
    end
    e.luse   = s_rst_n && s_valid && !s_flush && (h1 || h2);
    e.stall  = s_stall || e.luse;
    e.bubble = e.luse && !s_stall;
    e.cnt    = cnt_m[c];
    return e;
  endfunction

  task automatic model_step(input int c, input logic luse);
    if (!s_rst_n) begin
      for (int k = 0; k < 4; k++) sh[c][k] = '0;
      cnt_m[c] = '0;
    end else if (!s_stall) begin
      for (int k = 3; k >= 1; k--) sh[c][k] = sh[c][k-1];
      if (s_valid && !s_flush && !luse) sh[c][0] = '{v: 1'b1, rd: s_rd, we: s_rfwe, ld: s_ld};
      else sh[c][0] = '0;
      if (luse && cnt_m[c] != 32'hFFFF_FFFF) cnt_m[c] = cnt_m[c] + 1;
    end
  endtask

  task automatic go(input stim_t st, input bit chk = 1'b1);
    exp_t e0;
    exp_t e1;
    @(negedge clk);
    s_rst_n = st.rst_n;
    s_valid = st.valid;
    s_re1   = st.re1;
    s_re2   = st.re2;
    s_rfwe  = st.rfwe;
    s_ld    = st.ld;
    s_flush = st.flush;
    s_stall = st.stall;
    s_rs1   = st.rs1;
    s_rs2   = st.rs2;
    s_rd    = st.rd;
    s_wd    = st.wd;
    e0 = predict(0);
    e1 = predict(1);
    if (chk) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    model_step(0, e0.luse);
    model_step(1, e1.luse);
  endtask

  function automatic stim_t ins(input logic [4:0] rd, input logic we, input logic ld,
                                input logic [4:0] rs1, input logic re1,
                                input logic [4:0] rs2, input logic re2);
    stim_t st;
    st = '0;
    st.rst_n = 1'b1;
    st.valid = 1'b1;
    st.rd  = rd;
    st.rfwe = we;
    st.ld  = ld;
    st.rs1 = rs1;
    st.re1 = re1;
    st.rs2 = rs2;
    st.re2 = re2;
    st.wd  = {$urandom, $urandom, $urandom, $urandom};
    return st;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle per configuration.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("c0_stall", 32'(o0_stall), 32'(e.stall));
        chk("c0_bubble", 32'(o0_bubble), 32'(e.bubble));
        chk("c0_cnt", o0_cnt, e.cnt);
        if (!e.luse) begin
          chk("c0_sel1", 32'(o0_sel1), e.sel1);
          chk("c0_sel2", 32'(o0_sel2), e.sel2);
          chk("c0_d1", o0_d1, e.d1);
          chk("c0_d2", o0_d2, e.d2);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("c1_stall", 32'(o1_stall), 32'(e.stall));
        chk("c1_bubble", 32'(o1_bubble), 32'(e.bubble));
        chk("c1_cnt", o1_cnt, e.cnt);
        if (!e.luse) begin
          chk("c1_sel1", 32'(o1_sel1), e.sel1);
          chk("c1_sel2", 32'(o1_sel2), e.sel2);
          chk("c1_d1", o1_d1, e.d1);
          chk("c1_d2", o1_d2, e.d2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t st;
    for (int c = 0; c < 2; c++) begin
      cnt_m[c] = '0;
      for (int k = 0; k < 4; k++) sh[c][k] = '0;
    end

    // Reset: first edge unchecked (state undefined before it).
    st = ins(5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1);
    st.rst_n = 1'b0;
    go(st, 1'b0);
    go(st);
    st.stall = 1'b1;
    go(st);

    // ALU dependency forwarded from EX.
    go(ins(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    st = ins(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    st.wd[31:0] = 32'h11;
    go(st);

    // Youngest of two writers to x7 wins.
    go(ins(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    go(ins(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    st = ins(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    st.wd[63:0] = {32'hB, 32'hA};
    go(st);

    // Load-use, then forwarding once the load has aged enough.
    go(ins(5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    for (int i = 0; i < 4; i++) go(ins(5'd8, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0));

    // Flush suppresses the load-use stall.
    go(ins(5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    st = ins(5'd9, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
    st.flush = 1'b1;
    go(st);
    for (int i = 0; i < 3; i++) go(ins(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1));

    // Memory stall freezes everything for three cycles.
    go(ins(5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    st = ins(5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1);
    st.stall = 1'b1;
    for (int i = 0; i < 3; i++) go(st);
    st.stall = 1'b0;
    for (int i = 0; i < 3; i++) go(st);

    // x0 never forwarded.
    go(ins(5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    go(ins(5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1));

    // Reset in the middle of a load-use stall.
    go(ins(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    st = ins(5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    go(st);
    st.rst_n = 1'b0;
    go(st);
    st.rst_n = 1'b1;
    go(st);

    // Random traffic on a small register range to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      st = ins(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0));
      st.valid = ($urandom_range(0, 9) < 8);
      st.flush = ($urandom_range(0, 9) == 0);
      st.stall = ($urandom_range(0, 99) < 15);
      st.rst_n = ($urandom_range(0, 199) != 0);
      go(st);
    end

    for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    #4;
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
